// File: rtl/truth_table_sweeper.sv
// Truth-table engine: presents every N-input combination over a valid/ready stream,
// compares the external DUT's response against a minterm mask and tallies the result.
module truth_table_sweeper #(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [2**N-1:0]   mask_in,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [N-1:0]      vec,
  output logic              vec_valid,
  input  logic              vec_ready,
  input  logic              dut_s,
  output logic              exp_s,
  output logic [N:0]        ones_cnt,
  output logic [N:0]        mism_cnt,
  output logic              any_mism,
  output logic [N-1:0]      first_mism
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2**N-1:0]   mask;
  logic [N-1:0]      idx;
  logic [N-1:0]      idx_rev;
  logic              accept;
  logic              last_row;
  logic              row_mism;

  assign accept   = (state == S_RUN) && vec_ready;
  assign last_row = &idx;
  assign row_mism = dut_s != mask[idx];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (accept && last_row) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    idx_rev = '0;
    for (int i = 0; i < N; i++) idx_rev[i] = idx[N-1-i];
  end

  // Row presentation comes from registered state only; nothing from dut_s leaks out.
  assign vec_valid = busy;
  assign vec       = busy ? (MSB_FIRST ? idx : idx_rev) : '0;
  assign exp_s     = busy & mask[idx];

  // NOTE: the mask is an ordinary register (not a RAM), so it is cleared by
  // reset along with the counters; a restart after reset sweeps an all-zero function.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask       <= '0;
      idx        <= '0;
      ones_cnt   <= '0;
      mism_cnt   <= '0;
      any_mism   <= 1'b0;
      first_mism <= '0;
    end else begin
      if (state == S_IDLE) begin
        if (load) mask <= mask_in;
        if (start) begin
          idx        <= '0;
          ones_cnt   <= '0;
          mism_cnt   <= '0;
          any_mism   <= 1'b0;
          first_mism <= '0;
        end
      end
      if (accept) begin
        ones_cnt <= ones_cnt + {{N{1'b0}}, mask[idx]};
        if (row_mism) begin
          mism_cnt <= mism_cnt + {{N{1'b0}}, 1'b1};
          if (!any_mism) begin
            any_mism   <= 1'b1;
            first_mism <= idx;
          end
        end
        // The final row leaves idx parked; the next start clears it.
        if (!last_row) idx <= idx + N'(1);
      end
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: an N=4 instance driven by hand-written
// SoP/PoS functions and an N=2 bit-reversed XOR instance.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // N=4, MSB_FIRST=1 instance
  logic        load4, start4, vec_ready4, dut_s4;
  logic [15:0] mask_in4;
  logic        busy4, done4, vec_valid4, exp_s4, any4;
  logic [3:0]  vec4, first4;
  logic [4:0]  ones4, mism4;

  truth_table_sweeper #(.N(4), .MSB_FIRST(1'b1)) u_dut4 (
    .clk(clk), .reset(reset), .load(load4), .mask_in(mask_in4), .start(start4),
    .busy(busy4), .done(done4), .vec(vec4), .vec_valid(vec_valid4),
    .vec_ready(vec_ready4), .dut_s(dut_s4), .exp_s(exp_s4), .ones_cnt(ones4),
    .mism_cnt(mism4), .any_mism(any4), .first_mism(first4)
  );

  // Function under test for mask 16'h5363, a = vec[3] ... d = vec[0].
  logic a, b, c, d, sop, pos_bad;
  int   mode;
  assign {a, b, c, d} = vec4;
  assign sop = (~b & ~c) | (~a & b & ~c & d) | (b & c & ~d) | (a & b & ~d);
  // PoS with the maxterm for row 13 left out, so row 13 reads 1.
  assign pos_bad = (a | b | ~c | d) & (a | b | ~c | ~d) & (a | ~b | c | d) &
                   (a | ~b | ~c | ~d) & (~a | b | ~c | d) & (~a | b | ~c | ~d) &
                   (~a | ~b | ~c | ~d);
  assign dut_s4 = (mode == 0) ? sop : pos_bad;

  // N=2, MSB_FIRST=0 instance
  logic       load2, start2, vec_ready2, dut_s2;
  logic [3:0] mask_in2;
  logic       busy2, done2, vec_valid2, exp_s2, any2;
  logic [1:0] vec2, first2;
  logic [2:0] ones2, mism2;

  truth_table_sweeper #(.N(2), .MSB_FIRST(1'b0)) u_dut2 (
    .clk(clk), .reset(reset), .load(load2), .mask_in(mask_in2), .start(start2),
    .busy(busy2), .done(done2), .vec(vec2), .vec_valid(vec_valid2),
    .vec_ready(vec_ready2), .dut_s(dut_s2), .exp_s(exp_s2), .ones_cnt(ones2),
    .mism_cnt(mism2), .any_mism(any2), .first_mism(first2)
  );
  assign dut_s2 = vec2[1] ^ vec2[0];

  logic [15:0] exp_mask;

  task automatic kick4(input logic ld, input logic [15:0] m);
    load4 = ld; mask_in4 = m; start4 = 1'b1; vec_ready4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; load4 = 1'b0;
  endtask

  // Entered on the negedge of cycle 1 (first row). Tracks row index and ones count.
  task automatic sweep4(input bit toggle, input bit poke, input int abort_row,
                        output int done_cyc);
    int r;
    int ones;
    r = 0; ones = 0; done_cyc = -1;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      if (done4) begin
        done_cyc = cyc;
        check("done_busy", busy4, 0);
        check("done_valid", vec_valid4, 0);
        check("done_ones", ones4, ones);
        break;
      end
      check("busy", busy4, 1);
      check("vec_valid", vec_valid4, 1);
      check("vec", vec4, r);
      check("exp_s", exp_s4, exp_mask[r]);
      check("ones_run", ones4, ones);
      start4 = 1'b0; load4 = 1'b0;
      if (poke && cyc == 5) begin
        start4 = 1'b1; load4 = 1'b1; mask_in4 = 16'hFFFF;
      end
      vec_ready4 = toggle ? logic'(cyc % 2 == 1) : 1'b1;
      if (abort_row >= 0 && r == abort_row) begin
        reset = 1'b1;
        return;
      end
      if (vec_ready4) begin
        ones += int'(exp_mask[r]);
        r++;
      end
      @(negedge clk);
    end
    if (done_cyc < 0) check("done_timeout", 0, 1);
  endtask

  task automatic finals4(input string tag, input int ones, input int mism,
                         input logic anym, input int first);
    check({tag, "_ones"}, ones4, ones);
    check({tag, "_mism"}, mism4, mism);
    check({tag, "_any"}, any4, anym);
    check({tag, "_first"}, first4, first);
    @(negedge clk);
    check({tag, "_done_1cyc"}, done4, 0);
    check({tag, "_idle_busy"}, busy4, 0);
    check({tag, "_hold_ones"}, ones4, ones);
    check({tag, "_hold_mism"}, mism4, mism);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    int vseq[4];
    logic eseq[4];
    vseq = '{0, 2, 1, 3};
    eseq = '{1'b0, 1'b1, 1'b1, 1'b0};

    reset = 1'b1; mode = 0; exp_mask = 16'h0;
    load4 = 0; start4 = 0; vec_ready4 = 0; mask_in4 = '0;
    load2 = 0; start2 = 0; vec_ready2 = 0; mask_in2 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_valid", vec_valid4, 0);
    check("rst_vec", vec4, 0);
    check("rst_exp", exp_s4, 0);
    check("rst_ones", ones4, 0);
    check("rst_mism", mism4, 0);
    check("rst_any", any4, 0);
    check("rst_first", first4, 0);
    check("rst2_busy", busy2, 0);
    reset = 1'b0;
    @(negedge clk);

    // SoP DUT, continuous ready
    mode = 0; exp_mask = 16'h5363;
    kick4(1'b1, 16'h5363);
    sweep4(1'b0, 1'b0, -1, dc);
    check("sop_done_cyc", dc, 17);
    finals4("sop", 8, 0, 1'b0, 0);

    // Corrupted PoS DUT, mask retained from previous load
    mode = 1;
    kick4(1'b0, 16'h0000);
    sweep4(1'b0, 1'b0, -1, dc);
    check("pos_done_cyc", dc, 17);
    finals4("pos", 8, 1, 1'b1, 13);

    // Ready toggling 1,0,1,0...
    mode = 0;
    kick4(1'b0, 16'h0000);
    sweep4(1'b1, 1'b0, -1, dc);
    check("tog_done_cyc", dc, 32);
    finals4("tog", 8, 0, 1'b0, 0);

    // start/load with all-ones mask during RUN are ignored
    kick4(1'b0, 16'h0000);
    sweep4(1'b0, 1'b1, -1, dc);
    check("poke_done_cyc", dc, 17);
    finals4("poke", 8, 0, 1'b0, 0);

    // Reset on the edge where vec=7
    kick4(1'b0, 16'h0000);
    sweep4(1'b0, 1'b0, 7, dc);
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy4, 0);
    check("abort_valid", vec_valid4, 0);
    check("abort_done", done4, 0);
    check("abort_ones", ones4, 0);
    check("abort_mism", mism4, 0);
    check("abort_any", any4, 0);
    check("abort_first", first4, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", done4, 0);
    end
    // Mask was cleared: every row expects 0, the SoP DUT disagrees on its 8 minterms.
    exp_mask = 16'h0000;
    kick4(1'b0, 16'h0000);
    sweep4(1'b0, 1'b0, -1, dc);
    check("zero_done_cyc", dc, 17);
    finals4("zero", 0, 8, 1'b1, 0);

    // N=2 bit-reversed XOR
    load2 = 1'b1; mask_in2 = 4'b0110; start2 = 1'b1; vec_ready2 = 1'b1;
    @(negedge clk);
    load2 = 1'b0; start2 = 1'b0;
    dc = -1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (done2) begin
        dc = cyc;
        break;
      end
      if (cyc > 4) begin
        check("n2_overrun", cyc, 5);
        break;
      end
      check("n2_vec", vec2, vseq[cyc-1]);
      check("n2_exp", exp_s2, eseq[cyc-1]);
      check("n2_valid", vec_valid2, 1);
      @(negedge clk);
    end
    check("n2_done_cyc", dc, 5);
    check("n2_ones", ones2, 2);
    check("n2_mism", mism2, 0);
    check("n2_any", any2, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
